// File: rtl/fp_pkg.sv
// Shared definitions for the FP special-number dispatcher: class codes,
// opcodes, controller states and the special-case resolver.
package fp_pkg;

    typedef logic [2:0] fp_class_t;

    localparam fp_class_t CLS_ZERO = 3'b000;
    localparam fp_class_t CLS_NORM = 3'b001;
    localparam fp_class_t CLS_INFP = 3'b010;
    localparam fp_class_t CLS_INFN = 3'b011;
    localparam fp_class_t CLS_NAN  = 3'b100;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        special;
        logic [31:0] result;
    } resolve_t;

    // special=0 means the pair must go to the arithmetic core
    function automatic resolve_t fp_resolve(
        input logic        op,
        input logic [31:0] a,
        input logic [31:0] b,
        input fp_class_t   ca,
        input fp_class_t   cb
    );
        resolve_t r;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        r.special = 1'b1;
        r.result  = FP_QNAN;
        a_nan  = (ca == CLS_NAN);
        b_nan  = (cb == CLS_NAN);
        a_inf  = (ca == CLS_INFP) || (ca == CLS_INFN);
        b_inf  = (cb == CLS_INFP) || (cb == CLS_INFN);
        a_zero = (ca == CLS_ZERO);
        b_zero = (cb == CLS_ZERO);
        s      = a[31] ^ b[31];
        if (a_nan || b_nan) begin
            r.result = FP_QNAN;
        end else if (op == OP_ADD) begin
            if (a_inf && b_inf && (ca != cb))
                r.result = FP_QNAN;
            else if (a_inf)
                r.result = a;
            else if (b_inf)
                r.result = b;
            else if (a_zero && b_zero)
                r.result = {a[31] & b[31], 31'd0};
            else if (a_zero)
                r.result = b;
            else if (b_zero)
                r.result = a;
            else
                r.special = 1'b0;
        end else begin
            if ((a_inf && b_zero) || (b_inf && a_zero))
                r.result = FP_QNAN;
            else if (a_inf || b_inf)
                r.result = {s, 8'hFF, 23'd0};
            else if (a_zero || b_zero)
                r.result = {s, 31'd0};
            else
                r.special = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational special-number classifier for one IEEE-754 single.
// Denormals are not supported and fold into the NaN class.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_t   cls
);

    logic [7:0]  exp_f;
    logic [22:0] man;
    logic        man_nz;

    assign exp_f  = value[30:23];
    assign man    = value[22:0];
    assign man_nz = |man;

    always_comb begin
        cls = CLS_NORM;
        unique case (1'b1)
            (exp_f == 8'h00) && !man_nz: cls = CLS_ZERO;
            (exp_f == 8'h00) && man_nz:  cls = CLS_NAN;
            (exp_f == 8'hFF) && man_nz:  cls = CLS_NAN;
            (exp_f == 8'hFF) && !man_nz: cls = value[31] ? CLS_INFN : CLS_INFP;
            default:                     cls = CLS_NORM;
        endcase
    end

endmodule

// File: rtl/fp_special_dispatch.sv
// Sequencer in front of the multi-cycle FP core: resolves special operands
// locally, issues normal pairs to the core and guards it with a watchdog.
module fp_special_dispatch
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_op,
    output logic        core_req,
    input  logic        core_ready,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_op,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_special,
    output logic        out_timeout
);

    state_t      state, state_n;
    fp_class_t   cls_a_c, cls_b_c;
    fp_class_t   cls_a, cls_b;
    logic [15:0] cnt;
    logic        expired;
    resolve_t    res;

    fp_classify u_cls_a (.value(in_a), .cls(cls_a_c));
    fp_classify u_cls_b (.value(in_b), .cls(cls_b_c));

    assign expired = (cnt == 16'(TIMEOUT - 1));

    always_comb begin
        res = fp_resolve(core_op, core_a, core_b, cls_a, cls_b);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (in_valid) state_n = S_CLASSIFY;
            S_CLASSIFY: state_n = res.special ? S_RESP : S_ISSUE;
            S_ISSUE:    if (core_ready) state_n = S_WAIT;
            S_WAIT:     if (core_done || expired) state_n = S_RESP;
            S_RESP:     if (out_ready) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign core_req  = (state == S_ISSUE);
    assign out_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            core_a      <= '0;
            core_b      <= '0;
            core_op     <= OP_ADD;
            cls_a       <= CLS_ZERO;
            cls_b       <= CLS_ZERO;
            cnt         <= '0;
            out_result  <= '0;
            out_special <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE: if (in_valid) begin
                    core_a  <= in_a;
                    core_b  <= in_b;
                    core_op <= in_op;
                    cls_a   <= cls_a_c;
                    cls_b   <= cls_b_c;
                end
                S_CLASSIFY: if (res.special) begin
                    out_result  <= res.result;
                    out_special <= 1'b1;
                end
                S_ISSUE: if (core_ready) cnt <= '0;
                // a completion on the expiry cycle still counts as success
                S_WAIT: begin
                    if (core_done) begin
                        out_result <= core_result;
                    end else if (expired) begin
                        out_result  <= FP_QNAN;
                        out_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: if (out_ready) begin
                    out_special <= 1'b0;
                    out_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_special_dispatch.sv
// Directed self-checking bench for fp_special_dispatch (TIMEOUT=8).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fp_special_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_op = 1'b0;
    logic        core_req;
    logic        core_ready = 1'b0;
    logic [31:0] core_a, core_b;
    logic        core_op;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_special;
    logic        out_timeout;

    int total = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_special_dispatch #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .core_req(core_req), .core_ready(core_ready),
        .core_a(core_a), .core_b(core_b), .core_op(core_op),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_special(out_special),
        .out_timeout(out_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_flags_clr"}, {30'd0, out_special, out_timeout}, 32'd0);
    endtask

    task automatic run_special(input string tag, input logic op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        tick();
        in_valid = 1'b0;
        check({tag, "_n1_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_n1_req"}, {31'd0, core_req}, 32'd0);
        tick();
        check({tag, "_n2_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, out_result, exp);
        check({tag, "_special"}, {31'd0, out_special}, 32'd1);
        check({tag, "_timeout"}, {31'd0, out_timeout}, 32'd0);
        check({tag, "_n2_req"}, {31'd0, core_req}, 32'd0);
        handshake(tag);
    endtask

    initial begin
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_core_req", {31'd0, core_req}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {30'd0, out_special, out_timeout}, 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        rst_n = 1'b1;
        tick();

        run_special("add_inf", 1'b0, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000);
        run_special("mul_inf_zero", 1'b1, 32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000);
        run_special("mul_negzero", 1'b1, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
        run_special("add_inf_mix", 1'b0, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        run_special("add_zero_norm", 1'b0, 32'h0000_0000, 32'hC040_0000, 32'hC040_0000);
        run_special("mul_inf_neg", 1'b1, 32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000);
        run_special("add_zz_pos", 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000);

        // core path with a 3-cycle issue stall
        in_valid = 1'b1;
        in_a = 32'h3F80_0000;
        in_b = 32'h4000_0000;
        in_op = 1'b0;
        tick();
        in_valid = 1'b0;
        check("core_classify_req", {31'd0, core_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("core_stall_req", {31'd0, core_req}, 32'd1);
        end
        check("core_a", core_a, 32'h3F80_0000);
        check("core_b", core_b, 32'h4000_0000);
        check("core_op", {31'd0, core_op}, 32'd0);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        check("core_wait_req", {31'd0, core_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("core_wait_valid", {31'd0, out_valid}, 32'd0);
        end
        core_done = 1'b1;
        core_result = 32'h4040_0000;
        tick();
        core_done = 1'b0;
        core_result = '0;
        check("core_valid", {31'd0, out_valid}, 32'd1);
        check("core_result", out_result, 32'h4040_0000);
        check("core_flags", {30'd0, out_special, out_timeout}, 32'd0);
        handshake("core");

        // watchdog expiry: out_valid exactly 9 cycles after core_ready
        in_valid = 1'b1;
        in_a = 32'h3F80_0000;
        in_b = 32'h4000_0000;
        in_op = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("to_req", {31'd0, core_req}, 32'd1);
        check("to_core_op", {31'd0, core_op}, 32'd1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        for (int k = 1; k < 9; k++) begin
            check("to_early_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("to_valid", {31'd0, out_valid}, 32'd1);
        check("to_result", out_result, 32'h7FC0_0000);
        check("to_flags", {30'd0, out_special, out_timeout}, 32'd1);
        core_done = 1'b1;
        core_result = 32'h1234_5678;
        tick();
        core_done = 1'b0;
        check("late_done_result", out_result, 32'h7FC0_0000);
        check("late_done_valid", {31'd0, out_valid}, 32'd1);

        // back-pressure with a pending request
        in_valid = 1'b1;
        in_a = 32'h8000_0000;
        in_b = 32'h8000_0000;
        in_op = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_result", out_result, 32'h7FC0_0000);
            check("bp_flags", {30'd0, out_special, out_timeout}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp2_valid", {31'd0, out_valid}, 32'd1);
        check("bp2_result", out_result, 32'h8000_0000);
        check("bp2_special", {31'd0, out_special}, 32'd1);
        handshake("bp2");

        // asynchronous reset while waiting on the core
        in_valid = 1'b1;
        in_a = 32'h3F80_0000;
        in_b = 32'h4000_0000;
        in_op = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        tick();
        tick();
        check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_valid_req", {30'd0, out_valid, core_req}, 32'd0);
        check("arst_flags", {30'd0, out_special, out_timeout}, 32'd0);
        check("arst_core_a", core_a, 32'd0);
        check("arst_core_b", core_b, 32'd0);
        check("arst_core_op", {31'd0, core_op}, 32'd0);
        check("arst_out_result", out_result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_special("denorm", 1'b0, 32'h0000_0001, 32'h3F80_0000, 32'h7FC0_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
